// File: rtl/loader_pkg.sv
// ============================================================================
// loader_pkg: shared types and constants for the boot-time program loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

endpackage

`default_nettype wire

// File: rtl/program_loader_if.sv
// ============================================================================
// program_loader_if: byte-stream valid/ready handshake into the loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface program_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

`default_nettype wire

// File: rtl/word_packer.sv
// ============================================================================
// word_packer: gathers little-endian bytes into 32-bit words.
// Revision: 1.0
// ============================================================================
`default_nettype none

module word_packer
  import loader_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        accept,
  input  wire logic [7:0]  byte_in,
  output logic      [31:0] word,
  output logic             word_ready
);

  logic [1:0]  idx;
  logic [23:0] lanes;

  // The top lane is never stored: the word is presented while its last byte is on the bus.
  assign word_ready = accept && (idx == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_in, lanes};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx   <= 2'd0;
      lanes <= 24'd0;
    end else if (accept) begin
      case (idx)
        2'd0:    lanes[7:0]   <= byte_in;
        2'd1:    lanes[15:8]  <= byte_in;
        2'd2:    lanes[23:16] <= byte_in;
        default: lanes        <= lanes;
      endcase
      idx <= idx + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// program_loader: streams a program into instruction memory, then releases
// the CPU reset. Optional trailing checksum byte with LOADER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_loader
  import loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_WORDS     = 256
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  program_loader_if.slave               stream,
  output logic                          imem_we,
  output logic [ADDRESS_WIDTH-1:0]      imem_addr,
  output logic [DATA_WIDTH-1:0]         imem_wdata,
  output logic                          cpu_rst,
  output logic                          done,
  output logic                          err
);

  localparam int IDX_W = $clog2(MEM_WORDS) + 1;

  state_t            state, state_nx;
  logic [7:0]        hdr_lo;
  logic [15:0]       count;
  logic [IDX_W-1:0]  word_idx;
  logic              accept;
  logic              pack_accept;
  logic [15:0]       hdr_count;
  logic [31:0]       packed_word;
  logic              word_ready;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign stream.in_ready = (state == HDR0) || (state == HDR1) ||
                           (state == DATA) || (state == CSUM);
  assign accept      = stream.in_valid && stream.in_ready;
  assign pack_accept = accept && (state == DATA);
  assign hdr_count   = {stream.in_data, hdr_lo};
  assign last_word   = word_ready && ((32'(word_idx) + 32'd1) == 32'(count));

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .accept     (pack_accept),
    .byte_in    (stream.in_data),
    .word       (packed_word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HDR0;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      HDR0: if (accept) state_nx = HDR1;
      HDR1: begin
        if (accept) begin
          if (hdr_count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_nx = CSUM;
`else
            state_nx = DONE;
`endif
          end else if (32'(hdr_count) > 32'(MEM_WORDS)) begin
            state_nx = ERR;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_nx = CSUM;
`else
          state_nx = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (accept) state_nx = (stream.in_data == csum) ? DONE : ERR;
`endif
      DONE:    state_nx = DONE;
      ERR:     state_nx = ERR;
      default: state_nx = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_lo     <= 8'd0;
      count      <= 16'd0;
      word_idx   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (accept && (state == HDR0)) hdr_lo <= stream.in_data;
      if (accept && (state == HDR1)) count  <= hdr_count;
      imem_we <= word_ready;
      if (word_ready) begin
        imem_wdata <= DATA_WIDTH'(packed_word);
        imem_addr  <= ADDRESS_WIDTH'({word_idx, 2'b00});
        word_idx   <= word_idx + 1'b1;
      end
      // Lags the state by one cycle so the final write lands before the CPU's first fetch.
      cpu_rst <= (state != DONE);
      done    <= done | (state_nx == DONE);
      err     <= err  | (state_nx == ERR);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             csum <= 8'd0;
    else if (pack_accept) csum <= csum + stream.in_data;
  end
`endif

endmodule

`default_nettype wire
